// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester handshakes, the response channel
// and the operand/result bus to the shared combinational alu.
//   master : the environment (requesters, response consumer, alu)
//   slave  : the arbiter itself
interface alu_arbiter_if #(
    parameter int BITWIDTH = 32
);
    logic                req0_valid;
    logic                req0_ready;
    logic [BITWIDTH-1:0] req0_a;
    logic [BITWIDTH-1:0] req0_b;
    logic [3:0]          req0_op;

    logic                req1_valid;
    logic                req1_ready;
    logic [BITWIDTH-1:0] req1_a;
    logic [BITWIDTH-1:0] req1_b;
    logic [3:0]          req1_op;

    logic                rsp_valid;
    logic                rsp_id;
    logic [BITWIDTH-1:0] rsp_result;
    logic                rsp_err;
    logic                rsp_ready;

    logic [BITWIDTH-1:0] alu_a;
    logic [BITWIDTH-1:0] alu_b;
    logic [3:0]          alu_op;
    logic [BITWIDTH-1:0] alu_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        input  alu_a, alu_b, alu_op
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        output alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters using
// round-robin arbitration. Operands are registered onto the alu bus on accept,
// the alu result is registered one cycle later and held until consumed.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_arbiter_if slave modport (requests, response, alu bus)
module alu_arbiter #(
    parameter int BITWIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    state_t              state_nx;
    logic                last_grant;
    logic                grant;
    logic                grant_valid;
    logic                accept;
    logic                id_q;
    logic [BITWIDTH-1:0] a_q;
    logic [BITWIDTH-1:0] b_q;
    logic [3:0]          op_q;
    logic [BITWIDTH-1:0] result_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic                rsp_err_q;

    function automatic logic illegal_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: illegal_op = 1'b0;
            default:                                     illegal_op = 1'b1;
        endcase
    endfunction

    // On contention the requester that was not served last wins.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant       = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end
    end

    // Ready is masked by rst so no handshake is seen while reset is held.
    assign accept         = (state == IDLE) & grant_valid & ~rst;
    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q        <= grant ? bus.req1_a  : bus.req0_a;
                b_q        <= grant ? bus.req1_b  : bus.req0_b;
                op_q       <= grant ? bus.req1_op : bus.req0_op;
                last_grant <= grant;
                id_q       <= grant;
            end
            if (state == EXEC) begin
                result_q    <= bus.alu_result;
                rsp_id_q    <= id_q;
                rsp_err_q   <= illegal_op(op_q);
                rsp_valid_q <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test-plan steps followed by randomized traffic,
// checked against a transaction-level model of the arbiter and the alu.
module tb_alu_arbiter;
    localparam int W = 32;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b1101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.BITWIDTH(W)) bus();
    alu_arbiter #(.BITWIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int failed = 0;

    // model state
    logic         pend [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    logic [3:0]   pop [2];
    logic         busy, m_last, rr, rst_release;
    int           age, cyc, acc_id, acc_cyc, r_cyc;
    logic         q_id, q_err;
    logic [W-1:0] q_res;
    logic         rsp_seen, r_id, r_err;
    logic [W-1:0] r_res;
    int           seq [$];
    int           rc [$];

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, b, input logic [3:0] op);
        case (op)
            4'b0000: alu_ref = a + b;
            4'b1000: alu_ref = a - b;
            4'b0001: alu_ref = a << b[4:0];
            4'b0010: alu_ref = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0011: alu_ref = (a < b) ? 1 : 0;
            4'b0100: alu_ref = a ^ b;
            4'b0101: alu_ref = a >> b[4:0];
            4'b1101: alu_ref = $signed(a) >>> b[4:0];
            4'b0110: alu_ref = a | b;
            4'b0111: alu_ref = a & b;
            default: alu_ref = '0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        is_legal = (op == 4'b0000) || (op == 4'b1000) || (op == 4'b0001) || (op == 4'b0010) ||
                   (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0101) || (op == 4'b1101) ||
                   (op == 4'b0110) || (op == 4'b0111);
    endfunction

    // the shared alu lives in the bench
    always_comb bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        pend[n] = 1'b1;
        pa[n] = a;
        pb[n] = b;
        pop[n] = op;
    endtask

    task automatic drive();
        bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_op = pop[0];
        bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_op = pop[1];
        bus.rsp_ready  = rr;
    endtask

    task automatic model_reset();
        busy = 1'b0;
        m_last = 1'b1;
        age = 0;
    endtask

    // One clock cycle: drive, check combinational/registered outputs against
    // the model, then advance the model across the coming rising edge.
    task automatic step();
        logic e0, e1, ev;
        int n;
        @(negedge clk);
        if (rst_release) begin
            rst = 1'b0;
            rst_release = 1'b0;
        end
        drive();
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!busy) begin
            if (pend[0] && pend[1]) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else if (pend[0]) e0 = 1'b1;
            else if (pend[1]) e1 = 1'b1;
        end
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        ev = busy && (age >= 2);
        check("rsp_valid", bus.rsp_valid, ev);
        rsp_seen = 1'b0;
        acc_id = -1;
        if (ev) begin
            check("rsp_id", bus.rsp_id, q_id);
            check("rsp_result", bus.rsp_result, q_res);
            check("rsp_err", bus.rsp_err, q_err);
            if (rr) begin
                rsp_seen = 1'b1;
                r_id = bus.rsp_id;
                r_res = bus.rsp_result;
                r_err = bus.rsp_err;
                r_cyc = cyc;
            end
        end
        if (busy) begin
            if (ev && rr) busy = 1'b0;
            else age++;
        end else if (e0 || e1) begin
            n = e1 ? 1 : 0;
            busy = 1'b1;
            age = 1;
            m_last = e1;
            q_id = e1;
            q_res = alu_ref(pa[n], pb[n], pop[n]);
            q_err = !is_legal(pop[n]);
            pend[n] = 1'b0;
            acc_id = n;
            acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic wait_rsp(input int max);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!rsp_seen && k < max);
        check("rsp_timeout", rsp_seen, 1);
    endtask

    task automatic drain();
        rr = 1'b1;
        for (int k = 0; k < 60 && (busy || pend[0] || pend[1]); k++) step();
        check("drain_idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        model_reset();
        rst_release = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rst_release = 1'b0;
        rr = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
        end
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        check("reset_alu_a", bus.alu_a, 0);
        check("reset_alu_b", bus.alu_b, 0);
        check("reset_alu_op", {28'd0, bus.alu_op}, 0);
        rst_release = 1'b1;

        // 1: single add
        post(0, 32'd5, 32'd7, OP_ADD);
        rr = 1'b1;
        step();
        check("t1_acc_id", acc_id, 0);
        wait_rsp(6);
        check("t1_result", r_res, 32'd12);
        check("t1_id", r_id, 0);
        check("t1_err", r_err, 0);
        check("t1_latency", r_cyc - acc_cyc, 2);
        step();

        // 2: contention right after reset
        do_reset();
        post(0, 32'd10, 32'd3, OP_SUB);
        post(1, 32'd1, 32'd4, OP_SLL);
        wait_rsp(8);
        check("t2_first_id", r_id, 0);
        check("t2_first_res", r_res, 32'd7);
        wait_rsp(8);
        check("t2_second_id", r_id, 1);
        check("t2_second_res", r_res, 32'd16);

        // 3: fairness with both continuously valid
        do_reset();
        seq.delete();
        rc.delete();
        for (int k = 0; k < 40 && seq.size() < 6; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i]) post(i, $urandom, $urandom, OP_ADD);
            step();
            if (rsp_seen) begin
                seq.push_back(int'(r_id));
                rc.push_back(r_cyc);
            end
        end
        check("t3_count", seq.size(), 6);
        if (seq.size() > 0) check("t3_first", seq[0], 0);
        for (int k = 1; k < seq.size(); k++) begin
            check("t3_alternate", seq[k], 1 - seq[k-1]);
            check("t3_spacing", rc[k] - rc[k-1], 3);
        end
        drain();

        // 4: backpressure on a held response
        post(1, 32'h8000_0000, 32'd4, OP_SRA);
        step();
        check("t4_acc_id", acc_id, 1);
        rr = 1'b0;
        post(0, 32'd1, 32'd2, OP_ADD);
        repeat (6) step();
        rr = 1'b1;
        wait_rsp(3);
        check("t4_result", r_res, 32'hF800_0000);
        check("t4_id", r_id, 1);
        drain();

        // 5: illegal op followed by a legal xor
        post(0, 32'd9, 32'd9, 4'b1111);
        wait_rsp(8);
        check("t5_ill_result", r_res, 0);
        check("t5_ill_err", r_err, 1);
        post(0, 32'hFF, 32'h0F, OP_XOR);
        wait_rsp(8);
        check("t5_xor_result", r_res, 32'hF0);
        check("t5_xor_err", r_err, 0);

        // 6a: reset while in EXEC
        post(0, 32'h1234, 32'h5, OP_ADD);
        step();
        check("t6_acc", acc_id, 0);
        @(negedge clk);
        post(0, 32'hA, 32'hB, OP_ADD);
        post(1, 32'hC, 32'hD, OP_XOR);
        drive();
        rst = 1'b1;
        #1;
        check("t6e_rsp_valid", bus.rsp_valid, 0);
        check("t6e_ready0", bus.req0_ready, 0);
        check("t6e_ready1", bus.req1_ready, 0);
        check("t6e_alu_a", bus.alu_a, 0);
        check("t6e_alu_b", bus.alu_b, 0);
        model_reset();
        rst_release = 1'b1;
        step();
        check("t6e_grant", acc_id, 0);
        // 6b: reset while in RESP
        step();
        @(posedge clk);
        #2;
        check("t6r_valid_before", bus.rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("t6r_rsp_valid", bus.rsp_valid, 0);
        check("t6r_rsp_result", bus.rsp_result, 0);
        check("t6r_ready1", bus.req1_ready, 0);
        model_reset();
        post(0, 32'h11, 32'h22, OP_SUB);
        rst_release = 1'b1;
        step();
        check("t6r_grant", acc_id, 0);
        drain();

        // randomized traffic with random backpressure and op codes
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    post(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
            rr = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
